// File: rtl/adc_rx_deser.sv
// ADC receive deserialiser: samples DOUT on the FSM's sclk_n/cs_n strobes, builds frames and
// queues {channel, result} entries in a first-word-fall-through FIFO. Optional: ADC_RX_ZERO_CHECK_EN.
module adc_rx_deser #(
    parameter int PKG_SIZE    = 16,
    parameter int DATA_W      = 12,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sclk_n,
    input  logic                          cs_n,
    input  logic                          from_device,
    input  logic [2:0]                    ch_sel,
    output logic [DATA_W-1:0]             dout_data,
    output logic [2:0]                    dout_ch,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf,
    output logic                          frm_err,
    input  logic                          err_clr
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(PKG_SIZE + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
    typedef struct packed {
        logic [2:0]        ch;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [SYNC_STAGES-1:0] din_sync_q, sclk_sync_q, cs_sync_q;
    logic                   d_dout, d_sclk_n, d_cs_n;
    logic                   d_sclk_n_prev_q, d_cs_n_prev_q;
    logic                   sample_edge, frame_start, frame_end;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [2:0]         ch_q, ch_d;
    logic               push_q, push_d;
    logic               bad_frame;
`ifdef ADC_RX_ZERO_CHECK_EN
    logic               upper_nz_q, upper_nz_d;
`endif

    entry_t             mem_q [FIFO_DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               ovf_q, frm_err_q;
    logic               pop, full, wr_en, ovf_set;

    // Strobes ride through the same flop depth as DOUT so all three stay cycle-aligned.
    assign d_dout      = din_sync_q[SYNC_STAGES-1];
    assign d_sclk_n    = sclk_sync_q[SYNC_STAGES-1];
    assign d_cs_n      = cs_sync_q[SYNC_STAGES-1];
    assign sample_edge = d_sclk_n_prev_q & ~d_sclk_n;
    assign frame_start = d_cs_n_prev_q & ~d_cs_n;
    assign frame_end   = ~d_cs_n_prev_q & d_cs_n;

    // NOTE: every variable gets its default before the case so no path leaves a latch behind.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ch_d      = ch_q;
        push_d    = 1'b0;
        bad_frame = 1'b0;
`ifdef ADC_RX_ZERO_CHECK_EN
        upper_nz_d = upper_nz_q;
`endif
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                    ch_d    = ch_sel;
`ifdef ADC_RX_ZERO_CHECK_EN
                    upper_nz_d = 1'b0;
`endif
                end
            end
            SHIFT: begin
                if (sample_edge) begin
                    // Only DATA_W bits are kept; the upper frame bits fall off the top.
                    shift_d = {shift_q[DATA_W-2:0], d_dout};
                    cnt_d   = cnt_q + 1'b1;
`ifdef ADC_RX_ZERO_CHECK_EN
                    upper_nz_d = upper_nz_q | shift_q[DATA_W-1];
`endif
                    if (cnt_q == CNT_W'(PKG_SIZE - 1)) begin
                        state_d = frame_end ? IDLE : DONE;
`ifdef ADC_RX_ZERO_CHECK_EN
                        push_d    = ~upper_nz_d;
                        bad_frame = upper_nz_d;
`else
                        push_d    = 1'b1;
`endif
                    end else if (frame_end) begin
                        state_d   = IDLE;
                        bad_frame = 1'b1;
                    end
                end else if (frame_end) begin
                    state_d   = IDLE;
                    bad_frame = 1'b1;
                end
            end
            DONE: begin
                if (frame_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop     = dout_valid & dout_ready;
    assign full    = (level_q == LVL_W'(FIFO_DEPTH));
    assign wr_en   = push_q & (~full | pop);
    assign ovf_set = push_q & full & ~pop;

    always_comb begin
        level_d = level_q;
        if (wr_en && !pop)      level_d = level_q + 1'b1;
        else if (!wr_en && pop) level_d = level_q - 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_sync_q      <= '0;
            sclk_sync_q     <= '0;
            cs_sync_q       <= '0;
            d_sclk_n_prev_q <= 1'b0;
            d_cs_n_prev_q   <= 1'b0;
            state_q         <= IDLE;
            cnt_q           <= '0;
            shift_q         <= '0;
            ch_q            <= '0;
            push_q          <= 1'b0;
`ifdef ADC_RX_ZERO_CHECK_EN
            upper_nz_q      <= 1'b0;
`endif
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            ovf_q           <= 1'b0;
            frm_err_q       <= 1'b0;
        end else begin
            din_sync_q      <= {din_sync_q[SYNC_STAGES-2:0], from_device};
            sclk_sync_q     <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_n};
            cs_sync_q       <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            d_sclk_n_prev_q <= d_sclk_n;
            d_cs_n_prev_q   <= d_cs_n;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            shift_q         <= shift_d;
            ch_q            <= ch_d;
            push_q          <= push_d;
`ifdef ADC_RX_ZERO_CHECK_EN
            upper_nz_q      <= upper_nz_d;
`endif
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q         <= level_d;
            // Set wins over a simultaneous clear.
            ovf_q           <= ovf_set | (ovf_q & ~err_clr);
            frm_err_q       <= bad_frame | (frm_err_q & ~err_clr);
        end
    end

    // NOTE: storage is deliberately not reset; the level counter alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= '{ch: ch_q, data: shift_q};
    end

    assign head       = mem_q[rd_ptr_q];
    assign dout_valid = (level_q != '0);
    assign dout_data  = dout_valid ? head.data : '0;
    assign dout_ch    = dout_valid ? head.ch : '0;
    assign fifo_level = level_q;
    assign ovf        = ovf_q;
    assign frm_err    = frm_err_q;

endmodule

// File: tb/tb_adc_rx_deser.sv
// Self-checking bench for adc_rx_deser: scenario tasks plus a scoreboard of expected FIFO outputs,
// compared whenever the consumer pops.
module tb_adc_rx_deser;
    localparam int DATA_W = 12;
    typedef logic [DATA_W+2:0] sb_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sclk_n = 1'b1;
    logic              cs_n = 1'b1;
    logic              from_device = 1'b0;
    logic [2:0]        ch_sel = 3'd0;
    logic [DATA_W-1:0] dout_data;
    logic [2:0]        dout_ch;
    logic              dout_valid;
    logic              dout_ready = 1'b0;
    logic [2:0]        fifo_level;
    logic              ovf;
    logic              frm_err;
    logic              err_clr = 1'b0;

    int  checks = 0;
    int  errors = 0;
    sb_t sb[$];

    adc_rx_deser dut (
        .clk        (clk),
        .rst        (rst),
        .sclk_n     (sclk_n),
        .cs_n       (cs_n),
        .from_device(from_device),
        .ch_sel     (ch_sel),
        .dout_data  (dout_data),
        .dout_ch    (dout_ch),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fifo_level (fifo_level),
        .ovf        (ovf),
        .frm_err    (frm_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    // One clock: sample at the falling edge (scoreboard pop), then move to 1 ns after the rising edge.
    task automatic step();
        sb_t exp;
        @(negedge clk);
        if (dout_valid && dout_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got ch=%0d data=%h, required no output", dout_ch, dout_data);
            end else begin
                exp = sb.pop_front();
                if ({dout_ch, dout_data} !== exp) begin
                    errors++;
                    $display("FAIL sb_data: got ch=%0d data=%h, required ch=%0d data=%h",
                             dout_ch, dout_data, exp[DATA_W+2:DATA_W], exp[DATA_W-1:0]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] w, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            from_device = w[15-i];
            sclk_n = 1'b1;
            step(); step();
            sclk_n = 1'b0;
            step(); step();
        end
    endtask

    // Leaves the 16th falling sclk_n edge driven but not yet clocked.
    task automatic frame_head(input logic [2:0] ch, input logic [15:0] w);
        ch_sel = ch;
        cs_n = 1'b0;
        step(); step();
        send_bits(w, 0, 15);
        from_device = w[0];
        sclk_n = 1'b1;
        step(); step();
        sclk_n = 1'b0;
    endtask

    task automatic frame_tail();
        repeat (4) step();
        sclk_n = 1'b1;
        step(); step();
        cs_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic send_frame(input logic [2:0] ch, input logic [15:0] w, input bit exp_push);
        if (exp_push) sb.push_back({ch, w[DATA_W-1:0]});
        frame_head(ch, w);
        frame_tail();
    endtask

    task automatic drain();
        dout_ready = 1'b1;
        for (int i = 0; i < 40 && fifo_level != 0; i++) step();
        step();
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({dout_valid, fifo_level, ovf, frm_err, dout_data, dout_ch} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b lvl=%0d ovf=%b ferr=%b data=%h ch=%0d, required all 0",
                     dout_valid, fifo_level, ovf, frm_err, dout_data, dout_ch);
        end
        rst = 1'b0;
        repeat (4) step();
        checks++;
        if (dout_valid !== 1'b0 || frm_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got valid=%b ferr=%b, required 0 0", dout_valid, frm_err);
        end
    endtask

    task automatic test_single();
        dout_ready = 1'b1;
        sb.push_back({3'd5, 12'hABC});
        frame_head(3'd5, 16'h0ABC);
        repeat (3) step();
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got valid=%b at edge+3, required 0", dout_valid);
        end
        step();
        checks++;
        if (dout_valid !== 1'b1 || dout_data !== 12'hABC || dout_ch !== 3'd5 || fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL single_latency: got valid=%b data=%h ch=%0d lvl=%0d, required 1 abc 5 1",
                     dout_valid, dout_data, dout_ch, fifo_level);
        end
        step();
        checks++;
        if (dout_valid !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL single_pop: got valid=%b lvl=%0d, required 0 0", dout_valid, fifo_level);
        end
        frame_tail();
    endtask

    task automatic test_overflow();
        dout_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_frame(3'd1, 16'(k), k <= 4);
        checks++;
        if (fifo_level !== 3'd4 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full: got lvl=%0d ovf=%b, required 4 1", fifo_level, ovf);
        end
        repeat (3) step();
        checks++;
        if (dout_valid !== 1'b1 || dout_data !== 12'h001) begin
            errors++;
            $display("FAIL ovf_hold: got valid=%b data=%h, required 1 001", dout_valid, dout_data);
        end
        drain();
        checks++;
        if (fifo_level !== 3'd0 || sb.size() != 0) begin
            errors++;
            $display("FAIL ovf_drain: got lvl=%0d pending=%0d, required 0 0", fifo_level, sb.size());
        end
        clear_errors();
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got ovf=%b, required 0", ovf);
        end
    endtask

    task automatic test_full_pop();
        dout_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send_frame(3'd2, 16'(k), 1'b1);
        sb.push_back({3'd2, 12'h005});
        frame_head(3'd2, 16'h0005);
        repeat (3) step();
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        checks++;
        if (fifo_level !== 3'd4 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_level: got lvl=%0d ovf=%b, required 4 0", fifo_level, ovf);
        end
        frame_tail();
        drain();
        checks++;
        if (ovf !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL fullpop_drain: got ovf=%b pending=%0d, required 0 0", ovf, sb.size());
        end
    endtask

    task automatic test_abort();
        dout_ready = 1'b1;
        ch_sel = 3'd3;
        cs_n = 1'b0;
        step(); step();
        send_bits(16'hFFFF, 0, 9);
        sclk_n = 1'b1;
        step(); step();
        cs_n = 1'b1;
        repeat (3) step();
        checks++;
        if (frm_err !== 1'b1 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL abort_flag: got ferr=%b lvl=%0d, required 1 0", frm_err, fifo_level);
        end
        send_frame(3'd4, 16'h0123, 1'b1);
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL abort_next: got pending=%0d, required 0", sb.size());
        end
        clear_errors();
        checks++;
        if (frm_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear: got ferr=%b, required 0", frm_err);
        end
    endtask

    task automatic test_reset_mid();
        dout_ready = 1'b1;
        ch_sel = 3'd6;
        cs_n = 1'b0;
        step(); step();
        send_bits(16'hFFFF, 0, 6);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        send_bits(16'hFFFF, 6, 10);
        sclk_n = 1'b1;
        step(); step();
        cs_n = 1'b1;
        repeat (6) step();
        checks++;
        if (fifo_level !== 3'd0 || dout_valid !== 1'b0 || frm_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_nopush: got lvl=%0d valid=%b ferr=%b, required 0 0 0",
                     fifo_level, dout_valid, frm_err);
        end
        send_frame(3'd7, 16'h0FFF, 1'b1);
        drain();
        checks++;
        if (sb.size() != 0 || frm_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_next: got pending=%0d ferr=%b, required 0 0", sb.size(), frm_err);
        end
    endtask

    task automatic test_zero_check();
        dout_ready = 1'b1;
`ifdef ADC_RX_ZERO_CHECK_EN
        send_frame(3'd1, 16'h8ABC, 1'b0);
        checks++;
        if (frm_err !== 1'b1 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL zero_reject: got ferr=%b lvl=%0d, required 1 0", frm_err, fifo_level);
        end
        clear_errors();
`else
        send_frame(3'd1, 16'h8ABC, 1'b1);
        drain();
        checks++;
        if (frm_err !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL zero_ignore: got ferr=%b pending=%0d, required 0 0", frm_err, sb.size());
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_abort();
        test_reset_mid();
        test_zero_check();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got pending=%0d, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
